// File: rtl/spi_to_wb_master.sv
// SPI mode-0 slave to Wishbone master bridge. Each complete SPI frame
// (command, word address, payload) becomes one 32-bit Wishbone cycle.
// All SPI pins are oversampled in the Wishbone clock domain.
`timescale 1ns/1ps
module spi_to_wb_master #(
  parameter int unsigned            ADDRWIDTH    = 10,
  parameter int unsigned            DATAWIDTH    = 32,
  parameter logic [7:0]             TIMEOUT_CYC  = 8'd200,
  parameter logic [DATAWIDTH-1:0]   TIMEOUT_DATA = 32'hDEAD_DEAD
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RSTn_i,
  input  logic                 spi_sclk_i,
  input  logic                 spi_cs_n_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic                 spi_miso_oe_o,
  output logic [ADDRWIDTH-1:0] WBs_ADR_o,
  output logic                 WBs_CYC_o,
  output logic                 WBs_STB_o,
  output logic                 WBs_WE_o,
  output logic [3:0]           WBs_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  input  logic                 WBs_ACK_i,
  output logic [1:0]           fsm_top_st_o,
  output logic [1:0]           spi_fsm_st_o,
  output logic                 xfer_done_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {SPI_IDLE, SPI_HDR, SPI_DATA, SPI_DONE} spi_st_t;
  typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_ACKD, WB_TMO} wb_st_t;

  logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d;
  logic cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d;
  logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic rise_q, rise_d, fall_q, fall_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  spi_st_t spi_st_q, spi_st_d;
  wb_st_t  wb_st_q, wb_st_d;
  logic is_wr_q, is_wr_d;
  logic [DATAWIDTH-2:0] rx_sr_q, rx_sr_d;
  logic [7:0] word_addr_q, word_addr_d;
  logic [DATAWIDTH-1:0] miso_sr_q, miso_sr_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic cyc_q, cyc_d, we_q, we_d;
  logic [ADDRWIDTH-1:0] adr_q, adr_d;
  logic [DATAWIDTH-1:0] dat_q, dat_d, rdata_q, rdata_d;
  logic done_q, done_d, tmo_q, tmo_d;
  logic launch_rd, launch_wr;
  logic [7:0] launch_addr;

  // Next-state logic for synchronisers, SPI framing and the Wishbone cycle.
  always_comb begin
    sclk_meta_d = spi_sclk_i;
    sclk_sync_d = sclk_meta_q;
    cs_meta_d   = spi_cs_n_i;
    cs_sync_d   = cs_meta_q;
    mosi_meta_d = spi_mosi_i;
    mosi_sync_d = mosi_meta_q;
    sclk_prev_d = sclk_sync_q;
    cs_prev_d   = cs_sync_q;
    rise_d      = sclk_sync_q & ~sclk_prev_q;
    fall_d      = ~sclk_sync_q & sclk_prev_q;
    bit_cnt_d   = bit_cnt_q;
    spi_st_d    = spi_st_q;
    is_wr_d     = is_wr_q;
    rx_sr_d     = rx_sr_q;
    word_addr_d = word_addr_q;
    miso_sr_d   = miso_sr_q;
    wb_st_d     = wb_st_q;
    tmo_cnt_d   = tmo_cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    tmo_d       = 1'b0;
    launch_rd   = 1'b0;
    launch_wr   = 1'b0;
    launch_addr = word_addr_q;

    if (cs_sync_q) begin
      bit_cnt_d = '0;
      spi_st_d  = SPI_IDLE;
      miso_sr_d = '0;
    end else begin
      if (spi_st_q == SPI_IDLE && cs_prev_q) spi_st_d = SPI_HDR;
      if (rise_q) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        rx_sr_d   = {rx_sr_q[DATAWIDTH-3:0], mosi_sync_q};
        case (spi_st_q)
          SPI_HDR: begin
            if (bit_cnt_q == 6'd0) is_wr_d = mosi_sync_q;
            if (bit_cnt_q == 6'd15) begin
              word_addr_d = {rx_sr_q[6:0], mosi_sync_q};
              launch_addr = {rx_sr_q[6:0], mosi_sync_q};
              launch_rd   = ~is_wr_q;
              spi_st_d    = SPI_DATA;
            end
          end
          SPI_DATA: begin
            if (is_wr_q && bit_cnt_q == 6'd47) begin
              launch_wr = 1'b1;
              spi_st_d  = SPI_DONE;
            end else if (!is_wr_q && bit_cnt_q == 6'd55) begin
              spi_st_d  = SPI_DONE;
            end
          end
          default: ;
        endcase
      end
      // Read payload: load after the dummy byte, then shift one bit per falling edge.
      if (fall_q && !is_wr_q && spi_st_q == SPI_DATA) begin
        if (bit_cnt_q == 6'd24)
          miso_sr_d = (wb_st_q == WB_REQ) ? TIMEOUT_DATA : rdata_q;
        else if (bit_cnt_q > 6'd24)
          miso_sr_d = {miso_sr_q[DATAWIDTH-2:0], 1'b0};
      end
    end

    case (wb_st_q)
      WB_IDLE: begin
        if (launch_rd || launch_wr) begin
          wb_st_d   = WB_REQ;
          cyc_d     = 1'b1;
          we_d      = launch_wr;
          adr_d     = ADDRWIDTH'({launch_addr, 2'b00});
          if (launch_wr) dat_d = {rx_sr_q, mosi_sync_q};
          tmo_cnt_d = '0;
        end
      end
      WB_REQ: begin
        if (WBs_ACK_i) begin
          if (!we_q) rdata_d = WBs_DAT_i;
          done_d  = 1'b1;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          wb_st_d = WB_ACKD;
        end else if (tmo_cnt_q == TIMEOUT_CYC - 8'd1) begin
          rdata_d = TIMEOUT_DATA;
          tmo_d   = 1'b1;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          wb_st_d = WB_TMO;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: wb_st_d = WB_IDLE;
    endcase
  end

  // State registers; reset drops the Wishbone cycle and both FSMs immediately.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      sclk_meta_q <= 1'b0;  sclk_sync_q <= 1'b0;
      cs_meta_q   <= 1'b1;  cs_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b0;  mosi_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;  cs_prev_q   <= 1'b1;
      rise_q      <= 1'b0;  fall_q      <= 1'b0;
      bit_cnt_q   <= '0;
      spi_st_q    <= SPI_IDLE;
      wb_st_q     <= WB_IDLE;
      is_wr_q     <= 1'b0;
      rx_sr_q     <= '0;
      word_addr_q <= '0;
      miso_sr_q   <= '0;
      tmo_cnt_q   <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      sclk_meta_q <= sclk_meta_d;  sclk_sync_q <= sclk_sync_d;
      cs_meta_q   <= cs_meta_d;    cs_sync_q   <= cs_sync_d;
      mosi_meta_q <= mosi_meta_d;  mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;  cs_prev_q   <= cs_prev_d;
      rise_q      <= rise_d;       fall_q      <= fall_d;
      bit_cnt_q   <= bit_cnt_d;
      spi_st_q    <= spi_st_d;
      wb_st_q     <= wb_st_d;
      is_wr_q     <= is_wr_d;
      rx_sr_q     <= rx_sr_d;
      word_addr_q <= word_addr_d;
      miso_sr_q   <= miso_sr_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
    end
  end

  assign spi_miso_oe_o  = ~cs_sync_q;
  assign spi_miso_o     = ~cs_sync_q & miso_sr_q[DATAWIDTH-1];
  assign WBs_CYC_o      = cyc_q;
  assign WBs_STB_o      = cyc_q;
  assign WBs_WE_o       = we_q;
  assign WBs_BYTE_STB_o = {4{cyc_q}};
  assign WBs_ADR_o      = adr_q;
  assign WBs_DAT_o      = dat_q;
  assign fsm_top_st_o   = wb_st_q;
  assign spi_fsm_st_o   = spi_st_q;
  assign xfer_done_o    = done_q;
  assign timeout_o      = tmo_q;

endmodule

// File: tb/tb_spi_to_wb_master.sv
// Self-checking bench for spi_to_wb_master: drives SPI frames as a host,
// models a Wishbone slave with random wait states, and checks against a
// word-addressed reference memory.
`timescale 1ns/1ps
module tb_spi_to_wb_master;
  localparam int HALF = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, cyc, stb, we, ack, done, tmo;
  logic [9:0]  adr;
  logic [3:0]  bstb;
  logic [31:0] dat, rdat;
  logic [1:0]  top_st, spi_st;

  always #5 clk = ~clk;

  spi_to_wb_master #(.ADDRWIDTH(10), .DATAWIDTH(32), .TIMEOUT_CYC(8'd200),
                     .TIMEOUT_DATA(32'hDEAD_DEAD)) dut (
    .WBs_CLK_i(clk), .WBs_RSTn_i(rst_n),
    .spi_sclk_i(sclk), .spi_cs_n_i(cs_n), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(miso_oe),
    .WBs_ADR_o(adr), .WBs_CYC_o(cyc), .WBs_STB_o(stb), .WBs_WE_o(we),
    .WBs_BYTE_STB_o(bstb), .WBs_DAT_o(dat), .WBs_DAT_i(rdat), .WBs_ACK_i(ack),
    .fsm_top_st_o(top_st), .spi_fsm_st_o(spi_st),
    .xfer_done_o(done), .timeout_o(tmo));

  int n_checks = 0;
  int n_fail = 0;

  int clk_cnt = 0;
  always @(posedge clk) clk_cnt++;

  // Wishbone slave
  logic [31:0] smem [256];
  int  wait_left;
  bit  ack_en = 1'b1;
  int  max_wait = 0;
  bit  force_en = 1'b0;
  logic [31:0] force_val = '0;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0;
      rdat <= '0;
      wait_left <= 0;
      for (int i = 0; i < 256; i++) smem[i] <= init_val(i);
    end else begin
      ack <= 1'b0;
      if (cyc && stb && !ack && ack_en) begin
        if (wait_left == 0) begin
          ack <= 1'b1;
          if (we) smem[adr[9:2]] <= dat;
          rdat <= force_en ? force_val : smem[adr[9:2]];
          wait_left <= int'($urandom_range(max_wait, 0));
        end else begin
          wait_left <= wait_left - 1;
        end
      end
    end
  end

  // Reference model
  logic [31:0] ref_mem [256];
  task automatic init_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  // Bus monitor
  int n_cycles = 0, n_done = 0, n_tmo = 0, n_unstable = 0, n_tmo_st = 0;
  int cyc_len = 0, cyc_rise_clk = 0;
  logic prev_cyc = 1'b0;
  logic [9:0] cap_adr;
  logic [31:0] cap_dat;
  logic cap_we;
  logic [1:0] spi_hist [$];
  logic [1:0] last_spi = 2'd0;

  always @(negedge clk) begin
    if (cyc && !prev_cyc) begin
      n_cycles++;
      cyc_rise_clk = clk_cnt;
      cap_adr = adr; cap_dat = dat; cap_we = we;
      cyc_len = 0;
    end
    if (cyc) begin
      cyc_len++;
      if (adr !== cap_adr || dat !== cap_dat || we !== cap_we || bstb !== 4'hF || stb !== 1'b1)
        n_unstable++;
    end
    prev_cyc = cyc;
    if (done) n_done++;
    if (tmo) n_tmo++;
    if (top_st == 2'd3) n_tmo_st++;
    if (spi_st !== last_spi) begin
      spi_hist.push_back(spi_st);
      last_spi = spi_st;
    end
  end

  int rise_clk [56];

  task automatic spi_frame(input logic [55:0] tx, input int nbits, input bit release_cs,
                           output logic [55:0] rx);
    rx = '0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[55-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      rise_clk[i] = clk_cnt;
      rx = {rx[54:0], miso};
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    if (release_cs) begin
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      repeat (8 * HALF) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cyc, stb, we, bstb, adr, dat} !== '0) begin
      n_fail++;
      $display("FAIL reset_wb: got cyc=%b stb=%b we=%b bstb=%h adr=%h dat=%h want all 0", cyc, stb, we, bstb, adr, dat);
    end
    n_checks++;
    if ({top_st, spi_st, done, tmo, miso, miso_oe} !== '0) begin
      n_fail++;
      $display("FAIL reset_misc: got top=%0d spi=%0d done=%b tmo=%b miso=%b oe=%b want all 0", top_st, spi_st, done, tmo, miso, miso_oe);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({cyc, top_st, spi_st, miso_oe} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got cyc=%b top=%0d spi=%0d oe=%b want 0", cyc, top_st, spi_st, miso_oe);
    end
  endtask

  task automatic test_write();
    logic [55:0] rx;
    int c0 = n_cycles, d0 = n_done, u0 = n_unstable;
    spi_frame({8'h80, 8'h01, 32'h1234_5678, 8'h00}, 48, 1'b1, rx);
    ref_mem[1] = 32'h1234_5678;
    n_checks++;
    if (n_cycles - c0 !== 1) begin n_fail++; $display("FAIL write_count: got %0d cycles want 1", n_cycles - c0); end
    n_checks++;
    if (cap_adr !== {8'h01, 2'b00}) begin n_fail++; $display("FAIL write_adr: got %h want %h", cap_adr, {8'h01, 2'b00}); end
    n_checks++;
    if (cap_dat !== ref_mem[1]) begin n_fail++; $display("FAIL write_dat: got %h want %h", cap_dat, ref_mem[1]); end
    n_checks++;
    if (cap_we !== 1'b1) begin n_fail++; $display("FAIL write_we: got %b want 1", cap_we); end
    n_checks++;
    if (n_done - d0 !== 1) begin n_fail++; $display("FAIL write_done: got %0d pulses want 1", n_done - d0); end
    n_checks++;
    if (n_unstable !== u0) begin n_fail++; $display("FAIL write_stable: got %0d unstable clocks want 0", n_unstable - u0); end
    n_checks++;
    if (cyc_rise_clk - rise_clk[47] !== 4) begin n_fail++; $display("FAIL write_latency: got %0d clocks want 4", cyc_rise_clk - rise_clk[47]); end
  endtask

  task automatic test_read();
    logic [55:0] rx;
    logic [7:0] seq;
    int h0 = spi_hist.size();
    force_en = 1'b1;
    force_val = 32'hABCD_0011;
    spi_frame({8'h00, 8'h00, 8'h00, 32'h0}, 56, 1'b1, rx);
    force_en = 1'b0;
    n_checks++;
    if (rx[31:0] !== 32'hABCD_0011) begin n_fail++; $display("FAIL read_data: got %h want abcd0011", rx[31:0]); end
    n_checks++;
    if (rx[55:32] !== 24'h0) begin n_fail++; $display("FAIL read_hdr_miso: got %h want 000000", rx[55:32]); end
    seq = '1;
    if (spi_hist.size() - h0 == 4) seq = {spi_hist[h0], spi_hist[h0+1], spi_hist[h0+2], spi_hist[h0+3]};
    n_checks++;
    if (seq !== 8'b01_10_11_00) begin n_fail++; $display("FAIL read_spi_walk: got %b (%0d changes) want 01101100", seq, spi_hist.size() - h0); end
  endtask

  task automatic test_abort();
    logic [55:0] rx;
    int c0 = n_cycles;
    spi_frame({8'h80, 8'h05, 32'hFFFF_0000, 8'h00}, 30, 1'b1, rx);
    n_checks++;
    if (n_cycles !== c0) begin n_fail++; $display("FAIL abort_nocyc: got %0d cycles want 0", n_cycles - c0); end
    n_checks++;
    if ({top_st, spi_st} !== 4'h0) begin n_fail++; $display("FAIL abort_idle: got top=%0d spi=%0d want 0 0", top_st, spi_st); end
  endtask

  task automatic test_timeout();
    logic [55:0] rx;
    int t0 = n_tmo, d0 = n_done, s0 = n_tmo_st;
    ack_en = 1'b0;
    spi_frame({8'h00, 8'h3F, 8'h00, 32'h0}, 56, 1'b1, rx);
    ack_en = 1'b1;
    n_checks++;
    if (rx[31:0] !== 32'hDEAD_DEAD) begin n_fail++; $display("FAIL tmo_data: got %h want deaddead", rx[31:0]); end
    n_checks++;
    if (n_tmo - t0 !== 1) begin n_fail++; $display("FAIL tmo_pulse: got %0d want 1", n_tmo - t0); end
    n_checks++;
    if (n_done !== d0) begin n_fail++; $display("FAIL tmo_nodone: got %0d done pulses want 0", n_done - d0); end
    n_checks++;
    if (cyc_len !== 200) begin n_fail++; $display("FAIL tmo_len: got %0d clocks want 200", cyc_len); end
    n_checks++;
    if (cap_adr !== {8'h3F, 2'b00}) begin n_fail++; $display("FAIL tmo_adr: got %h want %h", cap_adr, {8'h3F, 2'b00}); end
    n_checks++;
    if (n_tmo_st - s0 !== 1) begin n_fail++; $display("FAIL tmo_state: got %0d clocks in state 3 want 1", n_tmo_st - s0); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] rx;
    int c0 = n_cycles, d0 = n_done;
    spi_frame({8'h80, 8'h02, 32'hA5A5_A5A5, 8'h00}, 48, 1'b1, rx);
    ref_mem[2] = 32'hA5A5_A5A5;
    spi_frame({8'h00, 8'h02, 8'h00, 32'h0}, 56, 1'b1, rx);
    n_checks++;
    if (rx[31:0] !== ref_mem[2]) begin n_fail++; $display("FAIL b2b_data: got %h want %h", rx[31:0], ref_mem[2]); end
    n_checks++;
    if (n_cycles - c0 !== 2 || n_done - d0 !== 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d cycles %0d acks want 2 2", n_cycles - c0, n_done - d0);
    end
  endtask

  task automatic test_random();
    logic [55:0] rx;
    logic [7:0]  a, r;
    logic [31:0] d;
    int u0 = n_unstable;
    max_wait = 3;
    for (int k = 0; k < 6; k++) begin
      a = 8'($urandom_range(255, 0));
      d = $urandom;
      spi_frame({8'h80 | 8'($urandom_range(127, 0)), a, d, 8'h00}, 48, 1'b1, rx);
      ref_mem[a] = d;
      r = ($urandom_range(1, 0) == 1) ? a : 8'($urandom_range(255, 0));
      spi_frame({8'($urandom_range(127, 0)), r, 8'($urandom), 32'h0}, 56, 1'b1, rx);
      n_checks++;
      if (rx[31:0] !== ref_mem[r] || cap_adr !== {r, 2'b00} || cap_we !== 1'b0) begin
        n_fail++; $display("FAIL rand_read[%0d]: got data=%h adr=%h we=%b want data=%h adr=%h we=0", k, rx[31:0], cap_adr, cap_we, ref_mem[r], {r, 2'b00});
      end
    end
    n_checks++;
    if (n_unstable !== u0) begin n_fail++; $display("FAIL rand_stable: got %0d unstable clocks want 0", n_unstable - u0); end
    max_wait = 0;
  endtask

  task automatic test_reset_mid();
    logic [55:0] rx;
    logic [7:0]  a;
    int c0;
    ack_en = 1'b0;
    spi_frame({8'h00, 8'h10, 8'h00, 32'h0}, 16, 1'b0, rx);
    for (int k = 0; k < 400 && cyc !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (cyc !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: got cyc=%b want 1 before reset", cyc); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cyc, stb} !== 2'b00) begin n_fail++; $display("FAIL rstmid_async: got cyc=%b stb=%b want 0 0", cyc, stb); end
    n_checks++;
    if ({we, bstb, adr, dat, top_st, spi_st, done, tmo, miso, miso_oe} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got we=%b bstb=%h adr=%h dat=%h top=%0d spi=%0d oe=%b want all 0", we, bstb, adr, dat, top_st, spi_st, miso_oe);
    end
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    init_ref();
    ack_en = 1'b1;
    repeat (10) @(negedge clk);
    c0 = n_cycles;
    a = 8'($urandom_range(255, 0));
    spi_frame({8'h00, a, 8'h00, 32'h0}, 56, 1'b1, rx);
    n_checks++;
    if (rx[31:0] !== ref_mem[a] || n_cycles - c0 !== 1) begin
      n_fail++; $display("FAIL rstmid_next: got data=%h cycles=%0d want data=%h cycles=1", rx[31:0], n_cycles - c0, ref_mem[a]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    init_ref();
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_to_wb_master.md
# spi_to_wb_master

SPI-slave-to-Wishbone-master bridge: an external host drives SPI mode-0 frames, and each complete frame becomes exactly one 32-bit Wishbone read or write cycle. The bridge sits directly upstream of the FPGA register block and drives its Wishbone slave port. It also supplies that block's `fsm_top_st_i` and `spi_fsm_st_i` status inputs. All SPI pins are oversampled in the Wishbone clock domain, so the block uses one clock only.

## Interface
Parameters:
- `ADDRWIDTH`, 10: Wishbone byte-address width.
- `DATAWIDTH`, 32: Wishbone data width.
- `TIMEOUT_CYC`, 8'd200: clocks allowed for `WBs_ACK_i` before the cycle is abandoned.
- `TIMEOUT_DATA`, 32'hDEAD_DEAD: read data returned on timeout.

Ports:
- `WBs_CLK_i` in 1: the only clock.
- `WBs_RSTn_i` in 1: reset, asynchronous and active-low.
- `spi_sclk_i` in 1: SPI clock, idle low; period ≥ 8 `WBs_CLK_i` periods.
- `spi_cs_n_i` in 1: chip select, active low.
- `spi_mosi_i` in 1: host data in, MSB first.
- `spi_miso_o` out 1: read data out, MSB first.
- `spi_miso_oe_o` out 1: MISO output enable.
- `WBs_ADR_o` out ADDRWIDTH: byte address; bits [1:0] always 0.
- `WBs_CYC_o` out 1: Wishbone cycle.
- `WBs_STB_o` out 1: Wishbone strobe.
- `WBs_WE_o` out 1: write enable.
- `WBs_BYTE_STB_o` out 4: byte enables; always 4'hF during a cycle.
- `WBs_DAT_o` out DATAWIDTH: write data.
- `WBs_DAT_i` in DATAWIDTH: read data.
- `WBs_ACK_i` in 1: acknowledge.
- `fsm_top_st_o` out 2: Wishbone FSM state.
- `spi_fsm_st_o` out 2: SPI FSM state.
- `xfer_done_o` out 1: one-clock pulse when a Wishbone cycle ends by ACK.
- `timeout_o` out 1: one-clock pulse when a Wishbone cycle ends by timeout.

## Operation
- **Synchronisers:** `spi_sclk_i`, `spi_cs_n_i` and `spi_mosi_i` each pass through 2-FF synchronisers. Reset values: sclk 0, cs_n 1, mosi 0.
  - Edge detect runs on synchronised sclk.
  - MOSI is sampled on rising edges.
  - MISO is updated on falling edges.
- **Frame layout:**
  - Byte 0 is the command. Bit 7 = 1 selects write, 0 selects read. Bits 6:0 are ignored.
  - Byte 1 is the word address. `WBs_ADR_o` = {addr[7:0], 2'b00}.
  - Write frame: 4 data bytes follow, MSB first, 48 bits total.
  - Read frame: 1 dummy byte (MOSI ignored, MISO 0), then 4 data bytes on MISO, 56 bits total.
- **Bit counter:** 6 bits wide. It clears when synchronised cs_n is high and increments on each rising edge. Bits beyond the frame length are ignored.
- **SPI FSM** (`spi_fsm_st_o`: 0 IDLE, 1 HDR, 2 DATA, 3 DONE):
  - IDLE → HDR on a cs_n falling edge.
  - HDR → DATA after bit 15 is sampled.
  - DATA → DONE after bit 47 (write) or bit 55 (read).
  - Any state → IDLE when cs_n is high.
- **Write launch:** a Wishbone write launches only when bit 47 is sampled. If cs_n rises earlier, the frame is aborted and no Wishbone cycle occurs.
- **Read launch:** a Wishbone read launches when bit 15 is sampled.
  - Returned data (or `TIMEOUT_DATA`) loads the MISO shift register on the falling edge following bit 23.
  - The register shifts on each following falling edge.
  - If the Wishbone cycle is still pending at that falling edge, `TIMEOUT_DATA` is loaded instead.
- **Wishbone FSM** (`fsm_top_st_o`: 0 IDLE, 1 REQ, 2 ACKD, 3 TMO):
  - IDLE → REQ on launch. `WBs_CYC_o`, `WBs_STB_o`, `WBs_WE_o`, `WBs_ADR_o` and `WBs_DAT_o` are registered and held stable throughout REQ.
  - REQ → ACKD on `WBs_ACK_i`. Read data is captured and `xfer_done_o` pulses.
  - REQ → TMO when the timeout counter reaches `TIMEOUT_CYC` without ACK. `timeout_o` pulses and read data becomes `TIMEOUT_DATA`.
  - CYC and STB drop in the same clock as the exit from REQ.
  - ACKD and TMO → IDLE after one clock.
- **Frame ends mid-cycle:** if cs_n rises while in REQ, the cycle still completes normally (ACK or timeout). It is never truncated.
- **MISO drive:** `spi_miso_oe_o` = ~synchronised cs_n. `spi_miso_o` is 0 whenever OE is low.
- **Reset values:** all outputs 0, except `WBs_BYTE_STB_o` = 4'h0 and `WBs_ADR_o` = 0. Both FSMs reset to IDLE.

## Timing
- **Launch latency:** Wishbone CYC/STB assert 4 clocks after the raw SCLK rising edge that samples the launch bit (2 synchroniser, 1 edge detect, 1 FSM register).
- **Write data:** `WBs_DAT_o` is stable from CYC assertion until CYC drops.
- **Read data:** captured in the same clock that `WBs_ACK_i` is high. A zero-wait slave (ACK the clock after STB) completes in 2 clocks.
- **Host constraint:** 8 SCLK periods ≥ `TIMEOUT_CYC` + 6 clocks, so that a timed-out read still returns `TIMEOUT_DATA` and not stale data.
- **Reset mid-operation:** asserting `WBs_RSTn_i` low drops CYC/STB immediately and returns both FSMs to IDLE. A frame in progress is lost. After reset, the next cs_n falling edge starts a fresh frame.

## Test plan
- **Write:** frame 0x80, 0x01, 0x12345678 → one Wishbone write. ADR 0x004, DAT 0x12345678, BYTE_STB 4'hF, WE 1. `xfer_done_o` pulses once.
- **Read:** frame 0x00, 0x00, dummy, 32 clocks, with the slave returning 0xABCD0011 → MISO shifts 0xABCD0011, MSB first. `spi_fsm_st_o` walks 0→1→2→3→0.
- **Abort:** cs_n rises after 30 bits of a write frame → no CYC assertion. Both FSMs return to IDLE.
- **Timeout:** read of address 0x3F with ACK held low → CYC held for `TIMEOUT_CYC` clocks, then `timeout_o` pulses. MISO returns 0xDEADDEAD and `fsm_top_st_o` passes through 3.
- **Back-to-back:** write 0x80 0x02 0xA5A5A5A5, then read 0x00 0x02, with cs_n high for 4 SCLK periods between frames → the read returns 0xA5A5A5A5. Exactly two Wishbone cycles occur.
- **Reset mid-cycle:** `WBs_RSTn_i` pulsed low while in REQ → CYC/STB go low asynchronously and all outputs return to 0. The next complete frame executes normally.
